// File: rtl/counter_pkg.sv
// Shared types and defaults for the up-counter datapath and its sequencer.
package counter_pkg;

  localparam int CNT_WIDTH_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/count_sequencer_if.sv
// Command channel into the sequencer: a (target, mode) pair with valid/ready.
interface count_sequencer_if
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_target;
  logic             cmd_period;

  modport master (
    output cmd_valid,
    output cmd_target,
    output cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  cmd_period,
    output cmd_ready
  );

endinterface

// File: rtl/tff_up_counter.sv
// Up counter built from toggle flip-flops with an AND carry chain.
// Bit n toggles when up_en is high and every lower bit is already 1.
module tff_up_counter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             clear_b,
  input  logic             up_en,
  input  logic             sclr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] t;

  // Toggle enables: bit 0 follows up_en, higher bits need all lower bits set.
  assign t[0] = up_en;

  for (genvar i = 1; i < WIDTH; i++) begin : g_carry
    assign t[i] = up_en & (&q[i-1:0]);
  end

  // Toggle register; synchronous clear wins over counting.
  always_ff @(posedge CLK or negedge clear_b) begin
    if (!clear_b) begin
      q <= '0;
    end else if (sclr) begin
      q <= '0;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Command-driven controller for the T-FF up counter: accepts a (target, mode)
// command, gates the counter's up-enable, and pulses done on terminal count.
module count_sequencer
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             clear_b,
  count_sequencer_if.slave cmd,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  seq_state_t       state;
  logic [WIDTH-1:0] target_q;
  logic             period_q;
  logic             up_en;
  logic             sclr;
  logic             terminal;

  assign terminal      = (count == target_q);
  assign cmd.cmd_ready = (state == IDLE);
  assign busy          = (state == RUN);

  // Counter control: clear on accept, abort or terminal; count otherwise unless paused.
  always_comb begin
    up_en = 1'b0;
    sclr  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd.cmd_valid) begin
          sclr = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          sclr = 1'b1;
        end else if (!pause) begin
          if (terminal) begin
            sclr = 1'b1;
          end else begin
            up_en = 1'b1;
          end
        end
      end
      default: begin
        sclr = 1'b1;
      end
    endcase
  end

  // Sequencer FSM with command registers and the registered done pulse.
  always_ff @(posedge CLK or negedge clear_b) begin
    if (!clear_b) begin
      state    <= IDLE;
      target_q <= '0;
      period_q <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            target_q <= cmd.cmd_target;
            period_q <= cmd.cmd_period;
            state    <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (!pause && terminal) begin
            done <= 1'b1;
            if (!period_q) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  tff_up_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .CLK     (CLK),
    .clear_b (clear_b),
    .up_en   (up_en),
    .sclr    (sclr),
    .q       (count)
  );

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: stimulus pushes expected post-edge
// outputs from a reference model, a separate monitor pops and compares.
module tb_count_sequencer;

  localparam int WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             done;
    logic             busy;
    logic             ready;
  } expect_t;

  logic             CLK;
  logic             clear_b;
  logic             pause;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count;

  count_sequencer_if #(.WIDTH(WIDTH)) cmd_bus ();

  count_sequencer #(
    .WIDTH (WIDTH)
  ) dut (
    .CLK     (CLK),
    .clear_b (clear_b),
    .cmd     (cmd_bus.slave),
    .pause   (pause),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .count   (count)
  );

  int checks   = 0;
  int failures = 0;
  int done_seen = 0;

  expect_t exp_q[$];

  // Reference model: a job of (target+1) unpaused cycles, progress counts through it.
  bit m_active;
  int m_target;
  bit m_periodic;
  int m_progress;
  bit m_done;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active   = 1'b0;
    m_target   = 0;
    m_periodic = 1'b0;
    m_progress = 0;
    m_done     = 1'b0;
  endtask

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic model_edge(input bit v, input int tgt, input bit per,
                            input bit pa, input bit ab);
    m_done = 1'b0;
    if (!m_active) begin
      if (v) begin
        m_active   = 1'b1;
        m_target   = tgt;
        m_periodic = per;
        m_progress = 0;
      end
    end else if (ab) begin
      m_active   = 1'b0;
      m_progress = 0;
    end else if (!pa) begin
      if (m_progress >= m_target) begin
        m_done     = 1'b1;
        m_progress = 0;
        m_active   = m_periodic;
      end else begin
        m_progress = m_progress + 1;
      end
    end
  endtask

  task automatic apply_stimulus(input bit v, input int tgt, input bit per,
                                input bit pa, input bit ab);
    expect_t e;
    @(negedge CLK);
    cmd_bus.cmd_valid  = v;
    cmd_bus.cmd_target = tgt[WIDTH-1:0];
    cmd_bus.cmd_period = per;
    pause              = pa;
    abort              = ab;
    model_edge(v, tgt, per, pa, ab);
    e.count = m_progress[WIDTH-1:0];
    e.done  = m_done;
    e.busy  = m_active;
    e.ready = !m_active;
    exp_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Async reset in the low clock phase, checked before the next rising edge.
  task automatic pulse_reset();
    @(negedge CLK);
    #1 clear_b = 1'b0;
    #1;
    check_output("rst_count", int'(count), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_done", int'(done), 0);
    check_output("rst_ready", int'(cmd_bus.cmd_ready), 1);
    #1 clear_b = 1'b1;
    model_reset();
  endtask

  // Monitor: compare DUT outputs shortly after each rising edge with the scoreboard head.
  initial begin
    expect_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("count", int'(count), int'(e.count));
        check_output("done", int'(done), int'(e.done));
        check_output("busy", int'(busy), int'(e.busy));
        check_output("cmd_ready", int'(cmd_bus.cmd_ready), int'(e.ready));
        if (done) done_seen++;
      end
    end
  end

  initial begin
    int drain;
    int tgt;
    cmd_bus.cmd_valid  = 1'b0;
    cmd_bus.cmd_target = '0;
    cmd_bus.cmd_period = 1'b0;
    pause              = 1'b0;
    abort              = 1'b0;
    clear_b            = 1'b0;
    model_reset();
    #2;
    check_output("init_count", int'(count), 0);
    check_output("init_busy", int'(busy), 0);
    check_output("init_done", int'(done), 0);
    check_output("init_ready", int'(cmd_bus.cmd_ready), 1);
    @(negedge CLK);
    clear_b = 1'b1;

    $display("[TB] one-shot target 5");
    apply_stimulus(1'b1, 5, 1'b0, 1'b0, 1'b0);
    idle_cycles(9);

    $display("[TB] periodic target 3 then abort");
    apply_stimulus(1'b1, 3, 1'b1, 1'b0, 1'b0);
    idle_cycles(20);
    apply_stimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle_cycles(6);

    $display("[TB] pause at count 2, one-shot target 4");
    apply_stimulus(1'b1, 4, 1'b0, 1'b0, 1'b0);
    idle_cycles(2);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle_cycles(6);

    $display("[TB] abort on terminal edge");
    apply_stimulus(1'b1, 2, 1'b0, 1'b0, 1'b0);
    idle_cycles(2);
    apply_stimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle_cycles(3);

    $display("[TB] periodic target 0, command during RUN");
    apply_stimulus(1'b1, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 7, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle_cycles(2);

    $display("[TB] reset mid-run at count 9, target 12");
    apply_stimulus(1'b1, 12, 1'b0, 1'b0, 1'b0);
    idle_cycles(9);
    pulse_reset();
    idle_cycles(2);
    apply_stimulus(1'b1, 1, 1'b0, 1'b0, 1'b0);
    idle_cycles(4);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      tgt = int'($urandom_range(15, 0));
      apply_stimulus(($urandom_range(3, 0) == 0), tgt, 1'($urandom_range(1, 0)),
                     ($urandom_range(7, 0) == 0), ($urandom_range(23, 0) == 0));
    end
    idle_cycles(20);

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge CLK);
      drain++;
    end
    #2;
    check_output("scoreboard_drained", exp_q.size(), 0);
    if (done_seen == 0) begin
      failures++;
      $display("[TB] FAIL done_activity actual=0 expected=nonzero");
    end
    checks++;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
